// File: rtl/lc3_writeback_param_if.sv
// lc3_writeback_param_if: writeback stage inputs (sources, indices) and registered read/status outputs.
interface lc3_writeback_param_if #(parameter int DATA_WIDTH = 16, parameter int REG_AW = 3);
  logic                  enable_writeback;
  logic [1:0]            W_Control;
  logic [DATA_WIDTH-1:0] aluout;
  logic [DATA_WIDTH-1:0] pcout;
  logic [DATA_WIDTH-1:0] memout;
  logic [DATA_WIDTH-1:0] npc;
  logic [REG_AW-1:0]     dr;
  logic [REG_AW-1:0]     sr1;
  logic [REG_AW-1:0]     sr2;
  logic [DATA_WIDTH-1:0] d1;
  logic [DATA_WIDTH-1:0] d2;
  logic [2:0]            psr;
  logic [DATA_WIDTH-1:0] wb_data;
  modport master (
    output enable_writeback, W_Control, aluout, pcout, memout, npc, dr, sr1, sr2,
    input  d1, d2, psr, wb_data
  );
  modport slave (
    input  enable_writeback, W_Control, aluout, pcout, memout, npc, dr, sr1, sr2,
    output d1, d2, psr, wb_data
  );
endinterface

// File: rtl/lc3_writeback_param.sv
// lc3_writeback_param: LC3 writeback mux, parametrised register file, NZP update and registered read ports.
module lc3_writeback_param #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_REGS      = 8,
  parameter int REG_AW        = $clog2(NUM_REGS),
  parameter int ENABLE_BYPASS = 1
) (
  input logic clock,
  input logic reset,
  lc3_writeback_param_if.slave wb
);
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_val, rd1, rd2;
  logic [2:0] psr_n;
  logic dr_ok, sr1_ok, sr2_ok;
  // Indices are widened before the range test so non-power-of-2 depths drop out-of-range accesses.
  always_comb begin
    wr_val = wb.W_Control == 2'd0 ? wb.aluout :
             wb.W_Control == 2'd1 ? wb.pcout  :
             wb.W_Control == 2'd2 ? wb.memout : wb.npc;
    dr_ok  = int'(wb.dr)  < NUM_REGS;
    sr1_ok = int'(wb.sr1) < NUM_REGS;
    sr2_ok = int'(wb.sr2) < NUM_REGS;
    rd1 = !sr1_ok ? '0 : (ENABLE_BYPASS != 0 && dr_ok && wb.sr1 == wb.dr) ? wr_val : rf[wb.sr1];
    rd2 = !sr2_ok ? '0 : (ENABLE_BYPASS != 0 && dr_ok && wb.sr2 == wb.dr) ? wr_val : rf[wb.sr2];
    psr_n = wr_val[DATA_WIDTH-1] ? 3'b100 : (wr_val == '0) ? 3'b010 : 3'b001;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      wb.d1      <= '0;
      wb.d2      <= '0;
      wb.psr     <= '0;
      wb.wb_data <= '0;
    end else if (wb.enable_writeback) begin
      if (dr_ok) rf[wb.dr] <= wr_val;
      wb.d1      <= rd1;
      wb.d2      <= rd2;
      wb.psr     <= psr_n;
      wb.wb_data <= wr_val;
    end
  end
endmodule

// File: tb/tb_lc3_writeback_param.sv
// tb_lc3_writeback_param: scoreboard bench over bypass/no-bypass 8x16 instances and a 6x32 instance.
module tb_lc3_writeback_param;
  typedef struct { logic [31:0] d1, d2, wb; logic [2:0] psr; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  logic [15:0] m [8];
  logic [31:0] mc [8];
  lc3_writeback_param_if #(16, 3) a ();
  lc3_writeback_param_if #(16, 3) b ();
  lc3_writeback_param_if #(32, 3) c ();
  lc3_writeback_param #(.DATA_WIDTH(16), .NUM_REGS(8), .ENABLE_BYPASS(1)) ua (.clock(clk), .reset(rst), .wb(a.slave));
  lc3_writeback_param #(.DATA_WIDTH(16), .NUM_REGS(8), .ENABLE_BYPASS(0)) ub (.clock(clk), .reset(rst), .wb(b.slave));
  lc3_writeback_param #(.DATA_WIDTH(32), .NUM_REGS(6), .ENABLE_BYPASS(1)) uc (.clock(clk), .reset(rst), .wb(c.slave));
  always #5 clk = ~clk;
  function automatic logic [2:0] nzp(input logic msb, input logic zero);
    return msb ? 3'b100 : zero ? 3'b010 : 3'b001;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic reset_model();
    for (int i = 0; i < 8; i++) begin m[i] = '0; mc[i] = '0; end
    ea = '{0, 0, 0, 3'b000};
    eb = ea;
    ec = ea;
  endtask
  task automatic settle_check(input string tag, input logic do_c);
    exp_t x;
    @(posedge clk);
    #1;
    x = qa.pop_front();
    chk({tag, " A.d1"}, {16'h0, a.d1}, x.d1);
    chk({tag, " A.d2"}, {16'h0, a.d2}, x.d2);
    chk({tag, " A.psr"}, {29'h0, a.psr}, {29'h0, x.psr});
    chk({tag, " A.wb"}, {16'h0, a.wb_data}, x.wb);
    x = qb.pop_front();
    chk({tag, " B.d1"}, {16'h0, b.d1}, x.d1);
    chk({tag, " B.d2"}, {16'h0, b.d2}, x.d2);
    chk({tag, " B.psr"}, {29'h0, b.psr}, {29'h0, x.psr});
    chk({tag, " B.wb"}, {16'h0, b.wb_data}, x.wb);
    x = qc.pop_front();
    if (do_c) begin
      chk({tag, " C.d1"}, c.d1, x.d1);
      chk({tag, " C.d2"}, c.d2, x.d2);
      chk({tag, " C.psr"}, {29'h0, c.psr}, {29'h0, x.psr});
      chk({tag, " C.wb"}, c.wb_data, x.wb);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic en, input logic [1:0] wc,
                      input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] mem, input logic [15:0] np,
                      input logic [2:0] dr, input logic [2:0] s1, input logic [2:0] s2);
    logic [15:0] wv;
    rst = r;
    a.enable_writeback = en; a.W_Control = wc; a.aluout = alu; a.pcout = pc; a.memout = mem; a.npc = np;
    a.dr = dr; a.sr1 = s1; a.sr2 = s2;
    b.enable_writeback = en; b.W_Control = wc; b.aluout = alu; b.pcout = pc; b.memout = mem; b.npc = np;
    b.dr = dr; b.sr1 = s1; b.sr2 = s2;
    c.enable_writeback = 1'b0;
    wv = wc == 2'd0 ? alu : wc == 2'd1 ? pc : wc == 2'd2 ? mem : np;
    if (r) reset_model();
    else if (en) begin
      ea.d1 = {16'h0, (s1 == dr) ? wv : m[s1]};
      ea.d2 = {16'h0, (s2 == dr) ? wv : m[s2]};
      eb.d1 = {16'h0, m[s1]};
      eb.d2 = {16'h0, m[s2]};
      ea.wb = {16'h0, wv};
      eb.wb = ea.wb;
      ea.psr = nzp(wv[15], wv == 16'h0);
      eb.psr = ea.psr;
      m[dr] = wv;
    end
    qa.push_back(ea);
    qb.push_back(eb);
    qc.push_back(ec);
    settle_check(tag, r);
  endtask
  task automatic stepc(input string tag, input logic [2:0] dr, input logic [31:0] val,
                       input logic [2:0] s1, input logic [2:0] s2);
    rst = 1'b0;
    a.enable_writeback = 1'b0;
    b.enable_writeback = 1'b0;
    c.enable_writeback = 1'b1; c.W_Control = 2'd2; c.memout = val;
    c.aluout = $urandom; c.pcout = $urandom; c.npc = $urandom;
    c.dr = dr; c.sr1 = s1; c.sr2 = s2;
    ec.d1 = s1 >= 3'd6 ? 32'h0 : (s1 == dr) ? val : mc[s1];
    ec.d2 = s2 >= 3'd6 ? 32'h0 : (s2 == dr) ? val : mc[s2];
    ec.wb = val;
    ec.psr = nzp(val[31], val == 32'h0);
    if (dr < 3'd6) mc[dr] = val;
    qa.push_back(ea);
    qb.push_back(eb);
    qc.push_back(ec);
    settle_check(tag, 1'b1);
  endtask
  initial begin
    c.enable_writeback = 1'b0; c.W_Control = '0; c.aluout = '0; c.pcout = '0; c.memout = '0; c.npc = '0;
    c.dr = '0; c.sr1 = '0; c.sr2 = '0;
    reset_model();
    step("rst0", 1, 0, 0, 16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 1, 2, 3);
    step("rst1", 1, 1, 0, 16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 1, 2, 3);
    step("idle", 0, 0, 1, 16'hffff, 16'hffff, 16'hffff, 16'hffff, 7, 6, 5);
    for (int i = 0; i < 8; i += 2)
      step($sformatf("rdall%0d", i), 0, 1, 0, 16'h0, 16'h1, 16'h2, 16'h3, 0, i[2:0], 3'(i + 1));
    for (int w = 0; w < 4; w++)
      step($sformatf("src%0d", w), 0, 1, 2'(w), 16'h0005, 16'h3001, 16'h8000, 16'h0000, 3, 3, 3);
    step("rf3", 0, 1, 3, 16'h0, 16'h0, 16'h0, 16'h7777, 0, 3, 3);
    step("pre2", 0, 1, 0, 16'h1111, 16'h0, 16'h0, 16'h0, 2, 0, 1);
    step("byp", 0, 1, 0, 16'h2222, 16'h0, 16'h0, 16'h0, 2, 2, 2);
    step("wrff", 0, 1, 2, 16'h0, 16'h0, 16'hffff, 16'h0, 5, 2, 5);
    for (int h = 0; h < 5; h++)
      step($sformatf("hold%0d", h), 0, 0, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    step("rdff", 0, 1, 1, 16'h0, 16'h0042, 16'h0, 16'h0, 7, 5, 2);
    step("rstmid", 1, 1, 0, 16'habcd, 16'h0, 16'h0, 16'h0, 4, 4, 4);
    step("post", 0, 1, 0, 16'h0001, 16'h0, 16'h0, 16'h0, 0, 4, 2);
    stepc("c_dr7", 7, 32'h0000_0001, 7, 0);
    stepc("c_neg", 5, 32'h8000_0000, 5, 7);
    stepc("c_dr6", 6, 32'h0000_0002, 5, 6);
    for (int i = 0; i < 6; i += 2)
      stepc($sformatf("c_rd%0d", i), 7, 32'h0, i[2:0], 3'(i + 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
